// File: rtl/uart_slot_pkg.sv
// Shared definitions for the UART slot core: FSM state encoding, register
// offsets and status bit positions of the read word.
package uart_slot_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [4:0] REG_DVSR = 5'd1;
  localparam logic [4:0] REG_WR   = 5'd2;
  localparam logic [4:0] REG_RD   = 5'd3;

  localparam int RX_EMPTY  = 8;
  localparam int TX_FULL   = 9;
  localparam int OVERRUN   = 10;
  localparam int FRAME_ERR = 11;

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous first-word-fall-through FIFO. The head word is always visible on
// rd_data; an extra pointer bit distinguishes full from empty.
module uart_fifo_sync #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_slot_core.sv
// UART peripheral for one MMIO slot: programmable 16x baud tick, 8N1 receiver
// and transmitter, one FIFO per direction, combinational status/data read word.
module uart_slot_core
  import uart_slot_pkg::*;
#(
  parameter int FIFO_AW  = 4,
  parameter int DVSR_W   = 11,
  parameter int DVSR_RST = 650
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        rx,
  output logic        tx
);

  logic              wr_en;
  logic              dvsr_we;
  logic              tx_wr;
  logic              rx_rd;
  logic [DVSR_W-1:0] dvsr;
  logic [DVSR_W-1:0] baud_cnt;
  logic              tick;
  logic              unused_ok;

  assign wr_en     = cs & write;
  assign dvsr_we   = wr_en && (addr == REG_DVSR);
  assign tx_wr     = wr_en && (addr == REG_WR);
  assign rx_rd     = wr_en && (addr == REG_RD);
  assign unused_ok = ^{read, wr_data[31:DVSR_W]};

  // >= lets a lowered divisor take effect at once instead of after a wrap.
  assign tick = (baud_cnt >= dvsr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvsr     <= DVSR_W'(DVSR_RST);
      baud_cnt <= '0;
    end else begin
      if (dvsr_we) dvsr <= wr_data[DVSR_W-1:0];
      baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
    end
  end

  // ---------------- FIFOs ----------------
  logic [7:0] rx_head;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;
  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] rx_shift, rx_shift_nx;

  uart_fifo_sync #(.DW(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_rd), .wr_data(rx_shift_nx),
    .rd_data(rx_head), .full(rx_full), .empty(rx_empty)
  );

  uart_fifo_sync #(.DW(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_wr), .pop(tx_pop), .wr_data(wr_data[7:0]),
    .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- RX path ----------------
  uart_state_t rx_state, rx_state_nx;
  logic [3:0]  rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_n, rx_n_nx;
  logic        rx_meta, rx_s;
  logic        overrun, frame_err;
  logic        set_ovr, set_ferr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_state  <= IDLE;
      rx_cnt    <= '0;
      rx_n      <= '0;
      rx_shift  <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_n     <= rx_n_nx;
      rx_shift <= rx_shift_nx;
      // A set event in the clearing cycle wins over the clear.
      if (set_ovr)    overrun <= 1'b1;
      else if (rx_rd) overrun <= 1'b0;
      if (set_ferr)   frame_err <= 1'b1;
      else if (rx_rd) frame_err <= 1'b0;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_n_nx     = rx_n;
    rx_shift_nx = rx_shift;
    rx_push     = 1'b0;
    set_ovr     = 1'b0;
    set_ferr    = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_s) begin
          rx_state_nx = START;
          rx_cnt_nx   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_cnt == 4'd7) begin
            rx_cnt_nx = '0;
            rx_n_nx   = '0;
            rx_state_nx = rx_s ? IDLE : DATA;
          end else begin
            rx_cnt_nx = rx_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_nx   = '0;
            rx_shift_nx = {rx_s, rx_shift[7:1]};
            if (rx_n == 3'd7) rx_state_nx = STOP;
            else              rx_n_nx = rx_n + 1'b1;
          end else begin
            rx_cnt_nx = rx_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_cnt == 4'd15) begin
            rx_state_nx = IDLE;
            if (!rx_s)                 set_ferr = 1'b1;
            else if (rx_full && !rx_rd) set_ovr = 1'b1;
            else                       rx_push  = 1'b1;
          end else begin
            rx_cnt_nx = rx_cnt + 1'b1;
          end
        end
      end
      default: rx_state_nx = IDLE;
    endcase
  end

  // ---------------- TX path ----------------
  uart_state_t tx_state, tx_state_nx;
  logic [3:0]  tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_n, tx_n_nx;
  logic [7:0]  tx_shift, tx_shift_nx;
  logic        tx_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_n     <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_n     <= tx_n_nx;
      tx_shift <= tx_shift_nx;
      tx       <= tx_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_n_nx     = tx_n;
    tx_shift_nx = tx_shift;
    tx_pop      = 1'b0;
    case (tx_state)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shift_nx = tx_head;
          tx_cnt_nx   = '0;
          tx_state_nx = START;
        end
      end
      START: begin
        if (tick) begin
          if (tx_cnt == 4'd15) begin
            tx_cnt_nx   = '0;
            tx_n_nx     = '0;
            tx_state_nx = DATA;
          end else begin
            tx_cnt_nx = tx_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tx_cnt == 4'd15) begin
            tx_cnt_nx   = '0;
            tx_shift_nx = {1'b0, tx_shift[7:1]};
            if (tx_n == 3'd7) tx_state_nx = STOP;
            else              tx_n_nx = tx_n + 1'b1;
          end else begin
            tx_cnt_nx = tx_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tx_cnt == 4'd15) tx_state_nx = IDLE;
          else                 tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nx = IDLE;
    endcase
    // The pin level follows the next state so tx is a clean flop output.
    case (tx_state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = tx_shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  // ---------------- read word ----------------
  always_comb begin
    rd_data            = '0;
    rd_data[7:0]       = rx_empty ? 8'h00 : rx_head;
    rd_data[RX_EMPTY]  = rx_empty;
    rd_data[TX_FULL]   = tx_full;
    rd_data[OVERRUN]   = overrun;
    rd_data[FRAME_ERR] = frame_err;
  end

endmodule

// File: tb/tb_uart_slot_core.sv
// Self-checking bench for uart_slot_core: register vectors, serial timing,
// FIFO limits and randomized RX traffic against a queue-based reference model.
module tb_uart_slot_core;
  import uart_slot_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rx, tx;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  assign rx = loop_en ? tx : rx_drv;

  uart_slot_core dut (
    .clk(clk), .rst(rst), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    cmp_cnt++;
    if (act < lo || act > hi) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model of the RX side ----------------
  logic [7:0] exp_q[$];
  bit         m_ovr = 0, m_ferr = 0;

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)              m_ferr = 1;
    else if (exp_q.size() == 16) m_ovr = 1;
    else                       exp_q.push_back(b);
  endfunction

  function automatic void model_pop();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    m_ovr  = 0;
    m_ferr = 0;
  endfunction

  function automatic logic [31:0] model_rd();
    logic [31:0] r;
    r = 32'h0;
    r[11] = m_ferr;
    r[10] = m_ovr;
    r[8]  = (exp_q.size() == 0);
    if (exp_q.size() != 0) r[7:0] = exp_q[0];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic pop_rx();
    wr(REG_RD, 32'h0);
    model_pop();
  endtask

  // One 8N1 frame at 64 clk/bit (dvsr=3). A bad stop bit is held low past the
  // sampling point, followed by an idle gap so the receiver can settle.
  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (64) @(negedge clk);
    end
    if (stop_ok) begin
      rx_drv = 1'b1;
      repeat (64) @(negedge clk);
    end else begin
      rx_drv = 1'b0;
      repeat (40) @(negedge clk);
      rx_drv = 1'b1;
      repeat (150) @(negedge clk);
    end
  endtask

  // Decode one frame from tx at 64 clk/bit; got=0 on timeout or bad stop.
  task automatic tx_get(output logic [7:0] b, output bit got);
    int t;
    got = 0; b = '0; t = 0;
    while (tx !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    if (tx !== 1'b0) return;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(negedge clk);
      b[i] = tx;
    end
    repeat (64) @(negedge clk);
    got = (tx === 1'b1);
  endtask

  // After a detected start-bit fall of 0x55, time nchg level changes.
  task automatic watch_bits(input string name, input int nchg, input int period, input int start_lo);
    int   t;
    logic prev;
    prev = 1'b0;
    for (int k = 1; k <= nchg; k++) begin
      t = 0;
      while (tx === prev && t < period + 8) begin @(negedge clk); t++; end
      check({name, "_level"}, tx, k % 2);
      if (k == 1) check_range({name, "_start_len"}, t, start_lo, period);
      else        check_range({name, "_bit_len"}, t, period - 1, period + 1);
      prev = tx;
    end
  endtask

  task automatic wait_tx_fall(input string name, input int limit);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < limit) begin @(negedge clk); t++; end
    check({name, "_tx_fall"}, tx, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset_tx", tx, 1'b1);
    check("async_reset_rd", rd_data, 32'h0000_0100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        cs;
    logic        write;
    logic        read;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] got_q[$];

  initial begin
    logic [7:0] b;
    bit         got;
    int         op;

    // register vectors applied while 0xA5 sits at the RX head
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_00FF, 32'h0000_00A5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd4,  32'h0000_0033, 32'h0000_00A5};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0000_00A5};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0000, 32'h0000_00A5};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd3,  32'h0000_0000, 32'h0000_00A5};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h0000_0000, 32'h0000_0100};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h0000_0000, 32'h0000_0100};

    // reset
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_rd", rd_data, 32'h0000_0100);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_rd", rd_data, 32'h0000_0100);

    // default divisor: 651 clk/tick, 10416 clk/bit; abandoned by a mid-frame reset
    wr(REG_WR, 32'h55);
    wait_tx_fall("dflt", 2);
    watch_bits("dflt", 2, 10416, 15 * 651 + 1);
    async_reset();

    // dvsr=3: 64 clk/bit, full 0x55 frame
    wr(REG_DVSR, 32'd3);
    wr(REG_WR, 32'h55);
    wait_tx_fall("dvsr3", 2);
    watch_bits("dvsr3", 9, 64, 61);
    repeat (64) @(negedge clk);
    check("dvsr3_idle_after_stop", tx, 1'b1);

    // loopback
    loop_en = 1'b1;
    wr(REG_WR, 32'hA5);
    repeat (700) @(negedge clk);
    loop_en = 1'b0;
    model_frame(8'hA5, 1);
    check("loopback_rd", rd_data, model_rd());
    foreach (vecs[i]) begin
      @(negedge clk);
      cs = vecs[i].cs; write = vecs[i].write; read = vecs[i].read;
      addr = vecs[i].addr; wr_data = vecs[i].data;
      @(negedge clk);
      cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0; wr_data = '0;
      check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp);
    end
    exp_q.delete();

    // TX FIFO full: 18 back-to-back writes, first byte leaves at once
    fork
      begin
        for (int k = 0; k < 17; k++) begin
          tx_get(b, got);
          check($sformatf("txfull_frame%0d_ok", k), got, 1'b1);
          if (got) got_q.push_back(b);
        end
      end
      begin
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = REG_WR;
        for (int i = 0; i < 18; i++) begin
          wr_data = i;
          @(negedge clk);
          if (i == 15) check("tx_full_after_16", rd_data[TX_FULL], 1'b0);
          if (i == 16) check("tx_full_after_17", rd_data[TX_FULL], 1'b1);
          if (i == 17) check("tx_full_after_18", rd_data[TX_FULL], 1'b1);
        end
        cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
      end
    join
    check("txfull_count", got_q.size(), 17);
    foreach (got_q[i]) check($sformatf("txfull_byte%0d", i), got_q[i], i);
    tx_get(b, got);
    check("txfull_no_extra", got, 1'b0);

    // RX overrun: 17 frames, no pops
    for (int i = 1; i <= 17; i++) begin
      send_rx(i[7:0], 1);
      model_frame(i[7:0], 1);
      if (i >= 16) check($sformatf("ovr_frame%0d_rd", i), rd_data, model_rd());
    end
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("ovr_head%0d", i), rd_data, model_rd());
      check($sformatf("ovr_byte%0d", i), rd_data[7:0], i);
      pop_rx();
    end
    check("ovr_drained_rd", rd_data, 32'h0000_0100);

    // framing error and start-bit glitch
    send_rx(8'h3C, 0);
    model_frame(8'h3C, 0);
    check("frame_err_rd", rd_data, 32'h0000_0900);
    pop_rx();
    check("frame_err_clear_rd", rd_data, model_rd());
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (700) @(negedge clk);
    check("glitch_rd", rd_data, 32'h0000_0100);

    // randomized RX traffic against the model
    for (int k = 0; k < 16; k++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        pop_rx();
      end else begin
        b = 8'($urandom_range(0, 255));
        got = ($urandom_range(0, 5) != 0);
        send_rx(b, got);
        model_frame(b, got);
      end
      check($sformatf("rand%0d_rd", k), rd_data, model_rd());
    end
    while (exp_q.size() != 0) begin
      pop_rx();
      check("rand_drain_rd", rd_data, model_rd());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_slot_core.md
Name: uart_slot_core

Overview:
- UART peripheral core that occupies MMIO slot 1 of the vanilla MMIO subsystem, downstream of the MMIO controller.
- Consumes one slot's cs/read/write/addr/wr_data strobes and returns rd_data for the controller's read mux.
- Contains a programmable baud-tick generator (16x oversampling), an 8N1 receiver, an 8N1 transmitter and one FIFO per direction.
- Drives the top-level tx pin and samples the top-level rx pin.

Parameters:
- FIFO_AW, 4, FIFO address width; each FIFO is 2**FIFO_AW = 16 entries deep.
- DVSR_W, 11, width of the baud divisor register.
- DVSR_RST, 650, divisor value after reset (100 MHz clock, 9600 baud).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- cs  in  1  slot chip select.
- read  in  1  slot read strobe; has no side effects in this core.
- write  in  1  slot write strobe.
- addr  in  5  slot register offset.
- wr_data  in  32  slot write data.
- rd_data  out  32  slot read data; combinational.
- rx  in  1  serial input; asynchronous to clk.
- tx  out  1  serial output; idles high.

Behaviour:
- Reset (rst=0, async): tx=1, dvsr=DVSR_RST, baud counter=0, both FIFOs empty, rx/tx FSMs IDLE, overrun=0, frame_err=0, rx synchronizer flops=1.
- Write decode: wr_en = cs & write, keyed on addr.
  - addr 1: dvsr <= wr_data[DVSR_W-1:0].
  - addr 2: push wr_data[7:0] into the TX FIFO if it is not full; the byte is silently dropped if full.
  - addr 3: pop the RX FIFO if it is not empty; clear overrun and frame_err in the same cycle.
  - All other addresses: write ignored.
- Read data: rd_data = {20'b0, frame_err, overrun, tx_full, rx_empty, rx_head[7:0]}, independent of addr.
  - rx_head is the first-word-fall-through head of the RX FIFO.
  - rx_head reads 0 when the RX FIFO is empty.
- Baud tick:
  - Counter increments every clk.
  - When cnt >= dvsr: tick=1 for one cycle and cnt <= 0. Using >= means a lowered dvsr takes effect without a 2**DVSR_W wrap.
  - dvsr=0 gives a tick every cycle; tick period is (dvsr+1) clk; bit time is 16 ticks.
- RX path:
  - rx passes through a 2-flop synchronizer (rx_s).
  - FSM states IDLE, START, DATA, STOP; s = tick counter (0..15), n = bit counter (0..7).
  - IDLE: rx_s=0 -> START, s=0.
  - START: at tick with s=7, if rx_s=0 -> DATA with s=0, n=0; otherwise (glitch) -> IDLE.
  - DATA: at tick with s=15, shift rx_s into the shift register MSB (so data is LSB first), s=0; after n=7 -> STOP.
  - STOP: at tick with s=15, sample rx_s.
    - rx_s=1: push the byte to the RX FIFO; if the FIFO is full, drop the byte and set overrun.
    - rx_s=0: discard the byte and set frame_err.
    - Return to IDLE in either case.
  - overrun and frame_err are sticky until an addr-3 write. If that write coincides with a set event in the same cycle, the set wins.
- TX path:
  - FSM states IDLE, START, DATA, STOP.
  - IDLE: tx=1; if the TX FIFO is not empty, pop the byte into the shift register -> START, s=0. The pop happens on a clk edge, not a tick.
  - START: tx=0 for 16 ticks.
  - DATA: tx=shift[0] for 16 ticks per bit, 8 bits, LSB first.
  - STOP: tx=1 for 16 ticks -> IDLE.
  - tx is registered, so it is glitch-free.
- FIFO rules:
  - Simultaneous push and pop when full: both are performed and the count is unchanged.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo depth; full/empty use an extra pointer bit.
- Reset mid-frame: the frame is abandoned immediately, tx=1 asynchronously, and FIFO contents are lost.

Decomposition:
- Package uart_slot_pkg holds:
  - typedef enum {IDLE, START, DATA, STOP} uart_state_t, shared by the RX and TX FSMs.
  - Register offset constants: REG_DVSR=1, REG_WR=2, REG_RD=3.
  - Status bit positions: RX_EMPTY=8, TX_FULL=9, OVERRUN=10, FRAME_ERR=11.
- One sub-module: uart_fifo_sync (parameterised data width/address width, FWFT, push/pop/full/empty), instantiated twice.
- The baud, RX and TX logic stay in the top module.

Test Plan:
- Reset: release rst -> tx=1; rd_data=0x0000_0100; dvsr=650 (verified via 10416 clk/bit timing, ±1 clk).
- dvsr: write addr1=3, then write addr2=0x55 -> tx falls within 2 clk.
  - 64 clk per bit; bit sequence 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop); frame length 640 clk.
- Loopback (tx tied to rx, dvsr=3): write 0xA5 -> after the frame, rd_data=0x0000_00A5; write addr3 -> rd_data=0x0000_0100.
- TX full: 18 back-to-back addr2 writes 0x00..0x11 -> tx_full (bit9) set after write 17 (one byte already popped); 0x11 dropped; exactly 0x00..0x10 appear on tx.
- RX overrun: drive 17 valid frames on rx without popping -> overrun=1 (rd_data bit10).
  - 16 pops then return bytes 1..16 in order.
  - The addr3 write clears overrun.
- Errors: stop bit driven 0 on byte 0x3C -> frame_err=1, rx_empty stays 1. rx low pulse of 4 ticks -> no byte received and no error.
